// File: rtl/mac_unit_pkg.sv
// ----------------------------------------------------------------------------
// mac_unit_pkg : shared state encoding and width defaults for the MAC datapath
// Revision     : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package mac_unit_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int LEN_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } mac_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_unit_if.sv
// ----------------------------------------------------------------------------
// mac_unit_if : operand/command and result signals of the MAC unit
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface mac_unit_if #(
  parameter int DATA_W = mac_unit_pkg::DATA_W_DEF,
  parameter int LEN_W  = mac_unit_pkg::LEN_W_DEF
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              ovf;
  logic              busy;

  modport master (
    output start, len, a_in, b_in, in_valid,
    input  in_ready, result, done, ovf, busy
  );

  modport slave (
    input  start, len, a_in, b_in, in_valid,
    output in_ready, result, done, ovf, busy
  );

endinterface

`default_nettype wire

// File: rtl/mac_unit_mul16.sv
// ----------------------------------------------------------------------------
// mul16    : combinational unsigned DATA_W x DATA_W -> 2*DATA_W multiplier
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mul16 #(
  parameter int DATA_W = 16
) (
  input  wire logic [DATA_W-1:0]   i_a,
  input  wire logic [DATA_W-1:0]   i_b,
  output logic      [2*DATA_W-1:0] o_p
);

  assign o_p = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};

endmodule

`default_nettype wire

// File: rtl/mac_unit.sv
// ----------------------------------------------------------------------------
// mac_unit : unsigned dot-product engine with sticky overflow and done pulse
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module mac_unit
  import mac_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mac_unit_if.slave   bus
);

  mac_state_t          r_state;
  mac_state_t          w_state_nxt;
  logic [LEN_W-1:0]    r_count;
  logic [DATA_W-1:0]   r_acc;
  logic                r_ovf_bit;
  logic [DATA_W-1:0]   r_result;
  logic                r_ovf;

  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_sum;
  logic                w_step_ovf;
  logic                w_accept;
  logic                w_last;
  logic                w_start;

  mul16 #(.DATA_W(DATA_W)) u_mul (
    .i_a (bus.a_in),
    .i_b (bus.b_in),
    .o_p (w_prod)
  );

  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod[DATA_W-1:0]};
  assign w_step_ovf = (|w_prod[2*DATA_W-1:DATA_W]) | w_sum[DATA_W];
  assign w_accept   = (r_state == ST_ACC) && bus.in_valid;
  assign w_last     = w_accept && (r_count == LEN_W'(1));
  assign w_start    = (r_state == ST_IDLE) && bus.start;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.len == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // result/ovf load on the edge entering DONE so they appear alongside done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count   <= '0;
      r_acc     <= '0;
      r_ovf_bit <= 1'b0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else if (w_start) begin
      r_count   <= bus.len;
      r_acc     <= '0;
      r_ovf_bit <= 1'b0;
      if (bus.len == '0) begin
        r_result <= '0;
        r_ovf    <= 1'b0;
      end
    end else if (w_accept) begin
      r_count   <= r_count - LEN_W'(1);
      r_acc     <= w_sum[DATA_W-1:0];
      r_ovf_bit <= r_ovf_bit | w_step_ovf;
      if (w_last) begin
        r_result <= w_sum[DATA_W-1:0];
        r_ovf    <= r_ovf_bit | w_step_ovf;
      end
    end
  end

  assign bus.in_ready = (r_state == ST_ACC);
  assign bus.done     = (r_state == ST_DONE);
  assign bus.busy     = (r_state != ST_IDLE);
  assign bus.result   = r_result;
  assign bus.ovf      = r_ovf;

endmodule

`default_nettype wire

// File: doc/mac_unit.md
MAC_UNIT -- requirements
Module: mac_unit

Interface
REQ-001 Parameter DATA_W, default 16: operand, accumulator and result width in bits.
REQ-002 Parameter LEN_W, default 4: width of the term-count input.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin a new dot product; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of terms (0..15); sampled with start.
REQ-007 a_in  input  DATA_W  operand A, unsigned.
REQ-008 b_in  input  DATA_W  operand B, unsigned.
REQ-009 in_valid  input  1  a_in/b_in hold a valid pair.
REQ-010 in_ready  output  1  block accepts a pair this cycle.
REQ-011 result  output  DATA_W  final sum; feeds the Data_register data_in.
REQ-012 done  output  1  one-cycle pulse; drives the Data_register write input.
REQ-013 ovf  output  1  overflow occurred in the last completed dot product.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, ACC, DONE.
REQ-016 IDLE->ACC on start with len!=0: load count=len and clear acc and the internal overflow bit.
REQ-017 IDLE->DONE on start with len==0: acc=0, overflow bit=0.
REQ-018 in_ready is 1 only in ACC; it is combinational from state only, not from in_valid.
REQ-019 A pair is accepted on a rising edge with in_valid=1 and in_ready=1: acc <= acc + (a_in*b_in) mod 2^DATA_W, and count <= count-1.
REQ-020 A cycle with in_valid=0 in ACC changes neither acc nor count.
REQ-021 The overflow bit is set on an accepted pair if the full 2*DATA_W product >= 2^DATA_W or the DATA_W-bit sum carries out; it is sticky until the next start.
REQ-022 ACC->DONE on the edge that accepts the pair with count==1.
REQ-023 In DONE: done=1 for exactly one cycle, result<=acc, ovf<=overflow bit, and the next state is IDLE.
REQ-024 Latency: result, ovf and done are visible in the cycle immediately after the last accept, or in the cycle after start when len==0.
REQ-025 result and ovf hold their values until the next DONE.
REQ-026 start is ignored in ACC and DONE; it does not restart the sequence and does not reload len.
REQ-027 Arithmetic is unsigned modulo 2^DATA_W; there is no saturation.

Reset
REQ-028 While rst=0: state=IDLE, acc=0, count=0, overflow bit=0, result=0, ovf=0, done=0, busy=0, in_ready=0, asynchronously and regardless of the clock.
REQ-029 Reset during ACC discards the partial sum; the first start after release begins a fresh dot product.
REQ-030 After release the block stays in IDLE until a start is sampled.

Structure
REQ-031 The shared definitions file/package holds the state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the DATA_W/LEN_W defaults, for reuse by the operand-fetch and register stages.
REQ-032 One sub-module, mul16: a combinational DATA_W x DATA_W -> 2*DATA_W unsigned multiplier, instantiated once.
REQ-033 The FSM, the count and the accumulator reside in mac_unit; result and ovf are registered outputs, and done and in_ready are decoded from state.

Verification
REQ-034 len=3; pairs (2,3),(4,5),(1,7) on consecutive cycles -> done pulses one cycle after the 3rd accept, result=0x0021, ovf=0, busy falls with done.
REQ-035 start with len=0 -> done the next cycle, result=0x0000, ovf=0, in_ready never asserted.
REQ-036 len=2; pairs (0x0100,0x0100),(0xFFFF,0x0001) -> result=0xFFFF, ovf=1; a following len=1 (3,3) -> result=0x0009, ovf=0.
REQ-037 len=2 with in_valid gaps (valid, 3 idle cycles, valid) -> exactly 2 accepts, done 1 cycle after the 2nd accept, and the sum is correct.
REQ-038 start pulsed during ACC with len=5 -> ignored; the original len=3 run completes with the correct result.
REQ-039 rst=0 mid-clock after 1 of 3 accepts -> all outputs 0 immediately; after release, start len=1 (6,7) -> result=0x002A.
